// File: rtl/store_checker.sv
// Store-stream verdict monitor for the single-cycle MIPS data-memory write port.
// Define STORE_CHECKER_LOG_EN to build the circular store log.
module store_checker #(
  parameter logic [31:0] TARGET_ADDR = 32'd84,
  parameter logic [31:0] TARGET_DATA = 32'd7,
  parameter logic [31:0] IGNORE_ADDR = 32'd80,
  parameter int unsigned TIMEOUT     = 1024,
  parameter int unsigned LOG_DEPTH   = 8
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         memwrite,
  input  logic [31:0]                  aluout,
  input  logic [31:0]                  writedata,
  output logic                         done,
  output logic                         pass,
  output logic                         fail,
  output logic                         timeout,
  output logic [31:0]                  fail_addr,
  output logic [31:0]                  fail_data,
  output logic [15:0]                  write_count,
  output logic [15:0]                  cycle_count,
  input  logic [$clog2(LOG_DEPTH)-1:0] log_idx,
  output logic [31:0]                  log_addr,
  output logic [31:0]                  log_data,
  output logic [$clog2(LOG_DEPTH):0]   log_count
);

  localparam int unsigned AW      = $clog2(LOG_DEPTH);
  localparam logic [15:0] TO_LAST = 16'(TIMEOUT - 1);

  typedef enum logic [1:0] {S_RUN, S_PASS, S_FAIL, S_TOUT} state_t;

  state_t state, state_next;
  logic   accept;

  assign accept = (state == S_RUN) && memwrite;

  // A store decision takes priority over timeout expiry in the same cycle.
  always_comb begin
    state_next = state;
    if (state == S_RUN) begin
      if (memwrite) begin
        if (aluout == TARGET_ADDR && writedata == TARGET_DATA)
          state_next = S_PASS;
        else if (aluout != IGNORE_ADDR)
          state_next = S_FAIL;
      end else if (cycle_count == TO_LAST) begin
        state_next = S_TOUT;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state       <= S_RUN;
      cycle_count <= '0;
      write_count <= '0;
      fail_addr   <= '0;
      fail_data   <= '0;
    end else begin
      state <= state_next;
      if (state == S_RUN)
        cycle_count <= cycle_count + 16'd1;
      if (accept && write_count != '1)
        write_count <= write_count + 16'd1;
      if (state == S_RUN && state_next == S_FAIL) begin
        fail_addr <= aluout;
        fail_data <= writedata;
      end
    end
  end

  assign done    = (state != S_RUN);
  assign pass    = (state == S_PASS);
  assign fail    = (state == S_FAIL) || (state == S_TOUT);
  assign timeout = (state == S_TOUT);

`ifdef STORE_CHECKER_LOG_EN
  logic [31:0] mem_addr [LOG_DEPTH];
  logic [31:0] mem_data [LOG_DEPTH];
  logic [AW-1:0] wptr;
  logic [AW-1:0] rptr;
  logic [AW:0]   count;

  always_ff @(posedge clk) begin
    if (!reset) begin
      wptr  <= '0;
      count <= '0;
    end else if (accept) begin
      wptr <= wptr + AW'(1);
      if (count != (AW+1)'(LOG_DEPTH))
        count <= count + (AW+1)'(1);
    end
  end

  // Contents survive reset; only the pointer and count are cleared.
  always_ff @(posedge clk) begin
    if (reset && accept) begin
      mem_addr[wptr] <= aluout;
      mem_data[wptr] <= writedata;
    end
  end

  // Once full, the write pointer sits on the oldest entry.
  assign rptr      = (count[AW] ? wptr : '0) + log_idx;
  assign log_addr  = mem_addr[rptr];
  assign log_data  = mem_data[rptr];
  assign log_count = count;
`else
  logic unused_log_idx;
  assign unused_log_idx = ^log_idx;
  assign log_addr  = '0;
  assign log_data  = '0;
  assign log_count = '0;
`endif

endmodule

// File: tb/tb_store_checker.sv
// Scoreboard bench for store_checker: a queue-based reference model predicts each
// cycle's outputs; a monitor compares them one step after every clock edge.
module tb_store_checker;
  localparam int unsigned TO    = 16;
  localparam int unsigned DEPTH = 8;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        memwrite = 1'b0;
  logic [31:0] aluout = '0;
  logic [31:0] writedata = '0;
  logic        done, pass, fail, timeout;
  logic [31:0] fail_addr, fail_data, log_addr, log_data;
  logic [15:0] write_count, cycle_count;
  logic [2:0]  log_idx = '0;
  logic [3:0]  log_count;

  store_checker #(
    .TARGET_ADDR(32'd84), .TARGET_DATA(32'd7), .IGNORE_ADDR(32'd80),
    .TIMEOUT(TO), .LOG_DEPTH(DEPTH)
  ) dut (
    .clk(clk), .reset(reset), .memwrite(memwrite), .aluout(aluout),
    .writedata(writedata), .done(done), .pass(pass), .fail(fail),
    .timeout(timeout), .fail_addr(fail_addr), .fail_data(fail_data),
    .write_count(write_count), .cycle_count(cycle_count), .log_idx(log_idx),
    .log_addr(log_addr), .log_data(log_data), .log_count(log_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        done, pass, fail, tout;
    logic [31:0] fa, fd;
    logic [15:0] wc, cc;
    logic [3:0]  lc;
    bit          chk_log;
    logic [31:0] la, ld;
  } exp_t;

  exp_t        sb[$];
  exp_t        e;
  int          n_vec = 0;
  int          n_bad = 0;
  int          want_idx = -1;

  // Reference model state
  bit          m_pass, m_fail, m_tout;
  int unsigned m_wc, m_cc;
  logic [31:0] m_fa, m_fd;
  logic [63:0] m_log[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(posedge clk) begin
    #1;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      chk("done", done, e.done);
      chk("pass", pass, e.pass);
      chk("fail", fail, e.fail);
      chk("timeout", timeout, e.tout);
      chk("fail_addr", fail_addr, e.fa);
      chk("fail_data", fail_data, e.fd);
      chk("write_count", write_count, e.wc);
      chk("cycle_count", cycle_count, e.cc);
      chk("log_count", log_count, e.lc);
      if (e.chk_log) begin
        chk("log_addr", log_addr, e.la);
        chk("log_data", log_data, e.ld);
      end
    end
  end

  task automatic step(input bit rst, input bit mw, input logic [31:0] a, input logic [31:0] d);
    exp_t x;
    int unsigned prev;
    int unsigned idx;
    @(negedge clk);
    reset = rst; memwrite = mw; aluout = a; writedata = d;
    if (!rst) begin
      m_pass = 0; m_fail = 0; m_tout = 0;
      m_wc = 0; m_cc = 0; m_fa = '0; m_fd = '0;
      m_log.delete();
    end else if (!(m_pass || m_fail || m_tout)) begin
      prev = m_cc;
      m_cc++;
      if (mw) begin
        if (m_wc < 65535) m_wc++;
        m_log.push_back({a, d});
        if (m_log.size() > DEPTH) void'(m_log.pop_front());
        if (a == 32'd84 && d == 32'd7) m_pass = 1;
        else if (a != 32'd80) begin m_fail = 1; m_fa = a; m_fd = d; end
      end else if (prev == TO - 1) begin
        m_tout = 1;
      end
    end
    x.done = m_pass | m_fail | m_tout;
    x.pass = m_pass;
    x.fail = m_fail | m_tout;
    x.tout = m_tout;
    x.fa = m_fa; x.fd = m_fd;
    x.wc = 16'(m_wc); x.cc = 16'(m_cc);
`ifdef STORE_CHECKER_LOG_EN
    x.lc = 4'(m_log.size());
    x.chk_log = (m_log.size() > 0);
    idx = 0;
    if (x.chk_log) begin
      if (want_idx >= 0) idx = want_idx;
      else idx = $urandom_range(0, m_log.size() - 1);
      x.la = m_log[idx][63:32];
      x.ld = m_log[idx][31:0];
    end
`else
    x.lc = '0;
    x.chk_log = 1;
    x.la = '0; x.ld = '0;
    idx = $urandom_range(0, DEPTH - 1);
`endif
    log_idx = 3'(idx);
    sb.push_back(x);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1, 0, 32'd0, 32'd0);
  endtask

  initial begin
    int r;
    logic [31:0] a, d;
    // Ignored stores then the success store, verdict holds with memwrite toggling
    step(0, 0, 0, 0); step(0, 0, 0, 0);
    step(1, 1, 80, 3); idle(2);
    step(1, 1, 80, 5); idle(2);
    step(1, 1, 84, 7);
    for (int i = 0; i < 20; i++) step(1, i[0], 32'd88, 32'(i));
    // Wrong data at the target address, later success store ignored
    step(0, 0, 0, 0);
    step(1, 1, 84, 6); step(1, 1, 84, 7); idle(2);
    // Unknown address, then mid-verdict reset and recovery
    step(0, 0, 0, 0);
    step(1, 1, 88, 7); idle(1);
    step(0, 0, 0, 0);
    step(1, 1, 84, 7); idle(1);
    // Timeout, then success on the last RUN cycle before expiry
    step(0, 0, 0, 0); idle(18);
    step(0, 0, 0, 0); idle(15); step(1, 1, 84, 7); idle(2);
    // Reset wins over a simultaneous success store
    step(0, 1, 84, 7); idle(1);
    // Log wraparound
    step(0, 0, 0, 0);
    for (int i = 1; i <= 10; i++) step(1, 1, 32'd80, 32'(i));
    want_idx = 0; step(1, 1, 84, 7);
    want_idx = 7; idle(1);
    want_idx = 0; idle(1);
    want_idx = -1;
    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      r = $urandom_range(0, 7);
      a = (r < 5) ? 32'd80 : (r < 7) ? 32'd84 : $urandom_range(0, 255);
      d = ($urandom_range(0, 1) == 1) ? 32'd7 : $urandom_range(0, 15);
      step(($urandom_range(0, 39) != 0), ($urandom_range(0, 3) == 0), a, d);
    end
    repeat (3) @(posedge clk);
    #2;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
